// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment capture path: active-high segment
// patterns {a..g}, decoded code values and the capture FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } cap_state_t;

    function automatic logic is_decimal(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment (active-high, bit 6 = a) to BCD decoder.
// Blank maps to CODE_BLANK, any unrecognised pattern to CODE_ERR.
module seg_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_ERR;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_ERR;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Receiver for the multiplexed seven-segment bus: stability-qualifies each digit
// pattern, decodes it to BCD and reports frames/errors. SEG_CAPTURE_DP_EN adds decimal-point capture.
module seg_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
`ifdef SEG_CAPTURE_DP_EN
    input  logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    err_flag
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef SEG_CAPTURE_DP_EN
    localparam int SAMP_W = 8;
`else
    localparam int SAMP_W = 7;
`endif

    logic [SAMP_W-1:0]       samp_raw;
    logic [SAMP_W-1:0]       samp_q;
    logic [SAMP_W-1:0]       prev_q;
    logic [SAMP_W-1:0]       samp_ah;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [NUM_DIGITS-1:0]   prev_sel_q;
    cap_state_t              state_q;
    cap_state_t              state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    commit;
    logic                    sel_ok;
    logic                    changed;
    logic [3:0]              code;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic [NUM_DIGITS-1:0]   mask_d;
    logic                    mask_full;
    logic                    frame_q;
    logic                    err_q;

`ifdef SEG_CAPTURE_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q;
    assign samp_raw = {seg_dp, seg_in};
`else
    assign samp_raw = seg_in;
`endif

    // One register stage on the bus plus a one-deep history for the stability compare
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q     <= '0;
            prev_q     <= '0;
            sel_q      <= '0;
            prev_sel_q <= '0;
        end else begin
            samp_q     <= samp_raw;
            sel_q      <= dig_sel;
            prev_q     <= samp_q;
            prev_sel_q <= sel_q;
        end
    end

    assign samp_ah = ACTIVE_LOW ? ~samp_q : samp_q;
    assign sel_ok  = $onehot(sel_q);
    assign changed = (samp_q != prev_q) || (sel_q != prev_sel_q);

    seg_decode u_decode (
        .pattern (samp_ah[6:0]),
        .code    (code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Commit fires only on the TRACK->HELD step, i.e. once the counter has
    // already reached STABLE_CYCLES and the newest sample still matches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            TRACK: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q >= CNT_W'(STABLE_CYCLES)) begin
                    state_d = HELD;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= {NUM_DIGITS{CODE_BLANK}};
            valid_q  <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (sel_q[k]) begin
                    digits_q[4*k +: 4] <= code;
                    valid_q[k]         <= is_decimal(code);
                end
            end
        end
    end

    // A full mask produces the pulse and restarts the frame on the same edge
    assign mask_full = &mask_q;
    assign mask_d    = (mask_full ? '0 : mask_q) | (commit ? sel_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            frame_q <= mask_full;
            if (commit && (code == CODE_ERR)) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef SEG_CAPTURE_DP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_q <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (sel_q[k]) begin
                    dp_q[k] <= samp_ah[7];
                end
            end
        end
    end

    assign dp_out = dp_q;
`endif

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign err_flag    = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: directed scenarios then random dwells, checked
// each cycle against a run-length reference model of the capture rules.
module tb_seg_capture;

    localparam int ND = 6;
    localparam int SC = 4;
    localparam bit AL = 1'b1;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg_in;
    logic [ND-1:0]   dig_sel;
    logic            err_clr;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   digit_valid;
    logic            frame_valid;
    logic            err_flag;
`ifdef SEG_CAPTURE_DP_EN
    logic            seg_dp;
    logic [ND-1:0]   dp_out;
`endif

    seg_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .ACTIVE_LOW    (AL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
`ifdef SEG_CAPTURE_DP_EN
        .seg_dp      (seg_dp),
        .dp_out      (dp_out),
`endif
        .dig_sel     (dig_sel),
        .err_clr     (err_clr),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .err_flag    (err_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4*ND-1:0] digits;
        logic [ND-1:0]   valid;
        logic            frame;
        logic            err;
        logic [ND-1:0]   dp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    localparam logic [6:0] P_BLANK = 7'b0000000;
    localparam logic [6:0] P_ERR   = 7'b1001001;

    // Reference model state: expected outputs plus the current run of identical samples
    logic [4*ND-1:0] m_digits;
    logic [ND-1:0]   m_valid;
    logic [ND-1:0]   m_mask;
    logic [ND-1:0]   m_dp;
    logic            m_err;
    logic            m_frame;
    logic [ND-1:0]   run_sel;
    logic [6:0]      run_pat;
    logic            run_dp;
    int              run_len;
    logic            pend;
    logic [ND-1:0]   pend_sel;
    logic [6:0]      pend_pat;
    logic            pend_dp;

    function automatic logic [3:0] ref_code(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (p == seg_tab[i]) return 4'(i);
        end
        if (p == P_BLANK) return 4'hF;
        return 4'hE;
    endfunction

    // A run of SC+1 identical one-hot samples commits on the edge after its last sample
    task automatic modelEdge(input logic r, input logic [ND-1:0] sel, input logic [6:0] pat,
                             input logic dp, input logic clr);
        logic [3:0] c;
        if (r) begin
            m_digits = '1;
            m_valid  = '0;
            m_mask   = '0;
            m_dp     = '0;
            m_err    = 1'b0;
            m_frame  = 1'b0;
            run_len  = 0;
            pend     = 1'b0;
        end else begin
            m_frame = (m_mask == '1);
            if (m_frame) m_mask = '0;
            c = ref_code(pend_pat);
            if (pend) begin
                for (int k = 0; k < ND; k++) begin
                    if (pend_sel[k]) begin
                        m_digits[4*k +: 4] = c;
                        m_valid[k]         = (c < 4'd10);
                        m_mask[k]          = 1'b1;
                        m_dp[k]            = pend_dp;
                    end
                end
            end
            if (pend && c == 4'hE) m_err = 1'b1;
            else if (clr)          m_err = 1'b0;
            pend = 1'b0;
            if ($countones(sel) == 1) begin
                if (run_len > 0 && sel == run_sel && pat == run_pat && dp == run_dp) begin
                    run_len++;
                end else begin
                    run_len = 1;
                    run_sel = sel;
                    run_pat = pat;
                    run_dp  = dp;
                end
                if (run_len == SC + 1) begin
                    pend     = 1'b1;
                    pend_sel = run_sel;
                    pend_pat = run_pat;
                    pend_dp  = run_dp;
                end
            end else begin
                run_len = 0;
            end
        end
    endtask

    // Drive one cycle (active-high values, converted to bus polarity) and queue the expectation
    task automatic applyStimulus(input logic r, input logic [ND-1:0] sel, input logic [6:0] pat,
                                 input logic dp, input logic clr);
        exp_t e;
        logic dp_eff;
        @(negedge clk);
        rst     = r;
        dig_sel = sel;
        seg_in  = AL ? ~pat : pat;
        err_clr = clr;
`ifdef SEG_CAPTURE_DP_EN
        seg_dp  = AL ? ~dp : dp;
        dp_eff  = dp;
`else
        dp_eff  = 1'b0;
`endif
        modelEdge(r, sel, pat, dp_eff, clr);
        e.digits = m_digits;
        e.valid  = m_valid;
        e.frame  = m_frame;
        e.err    = m_err;
        e.dp     = m_dp;
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input logic [ND-1:0] sel, input logic [6:0] pat,
                        input logic dp, input logic clr);
        repeat (n) applyStimulus(1'b0, sel, pat, dp, clr);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (digits_out !== e.digits) begin
            errors++;
            $display("[TB] FAIL digits_out: got %h expected %h at %0t", digits_out, e.digits, $time);
        end
        checks++;
        if (digit_valid !== e.valid) begin
            errors++;
            $display("[TB] FAIL digit_valid: got %b expected %b at %0t", digit_valid, e.valid, $time);
        end
        checks++;
        if (frame_valid !== e.frame) begin
            errors++;
            $display("[TB] FAIL frame_valid: got %b expected %b at %0t", frame_valid, e.frame, $time);
        end
        checks++;
        if (err_flag !== e.err) begin
            errors++;
            $display("[TB] FAIL err_flag: got %b expected %b at %0t", err_flag, e.err, $time);
        end
`ifdef SEG_CAPTURE_DP_EN
        checks++;
        if (dp_out !== e.dp) begin
            errors++;
            $display("[TB] FAIL dp_out: got %b expected %b at %0t", dp_out, e.dp, $time);
        end
`endif
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic [ND-1:0] sel;
        logic [6:0]    pat;
        logic          dp;
        int            len;
        int            pick;

        rst     = 1'b1;
        dig_sel = '0;
        seg_in  = AL ? 7'h7F : 7'h00;
        err_clr = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
        seg_dp  = AL;
`endif
        $display("[TB] reset");
        applyStimulus(1'b1, '0, P_BLANK, 1'b0, 1'b0);
        applyStimulus(1'b1, '0, P_BLANK, 1'b0, 1'b0);

        $display("[TB] single digit latency");
        hold(6, 6'b000001, seg_tab[0], 1'b0, 1'b0);
        hold(2, '0, P_BLANK, 1'b0, 1'b0);

        $display("[TB] full scan 1,2,3,4,5,9");
        hold(6, 6'b000001, seg_tab[1], 1'b0, 1'b0);
        hold(6, 6'b000010, seg_tab[2], 1'b0, 1'b0);
        hold(6, 6'b000100, seg_tab[3], 1'b0, 1'b0);
        hold(6, 6'b001000, seg_tab[4], 1'b0, 1'b0);
        hold(6, 6'b010000, seg_tab[5], 1'b0, 1'b0);
        hold(6, 6'b100000, seg_tab[9], 1'b0, 1'b0);
        hold(3, '0, P_BLANK, 1'b0, 1'b0);

        $display("[TB] unstable toggle on digit 2");
        applyStimulus(1'b1, '0, P_BLANK, 1'b0, 1'b0);
        repeat (6) begin
            hold(2, 6'b000100, seg_tab[8], 1'b0, 1'b0);
            hold(2, 6'b000100, seg_tab[7], 1'b0, 1'b0);
        end

        $display("[TB] blank, error and err_clr");
        hold(6, 6'b000010, P_BLANK, 1'b0, 1'b0);
        hold(6, 6'b000010, P_ERR, 1'b0, 1'b0);
        hold(1, '0, P_BLANK, 1'b0, 1'b1);
        hold(2, '0, P_BLANK, 1'b0, 1'b0);
        hold(6, 6'b001000, P_ERR, 1'b0, 1'b1);
        hold(2, '0, P_BLANK, 1'b0, 1'b1);

        $display("[TB] invalid select and mid-dwell reset");
        hold(10, 6'b000011, seg_tab[5], 1'b0, 1'b0);
        hold(3, 6'b010000, seg_tab[6], 1'b0, 1'b0);
        applyStimulus(1'b1, 6'b010000, seg_tab[6], 1'b0, 1'b0);
        hold(3, 6'b010000, seg_tab[6], 1'b0, 1'b0);
        hold(2, '0, P_BLANK, 1'b0, 1'b0);

        $display("[TB] decimal point on digit 3");
        hold(6, 6'b001000, seg_tab[5], 1'b1, 1'b0);
        hold(6, 6'b001000, seg_tab[5], 1'b0, 1'b0);

        $display("[TB] random dwells");
        for (int d = 0; d < 120; d++) begin
            pick = $urandom_range(0, 9);
            if (pick < 8)       sel = ND'(1) << $urandom_range(0, ND - 1);
            else if (pick == 8) sel = '0;
            else                sel = ND'($urandom_range(0, (1 << ND) - 1));
            pick = $urandom_range(0, 9);
            if (pick < 7)       pat = seg_tab[$urandom_range(0, 9)];
            else if (pick == 7) pat = P_BLANK;
            else                pat = 7'($urandom_range(0, 127));
            dp  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 29) == 0) applyStimulus(1'b1, sel, pat, dp, 1'b0);
            repeat (len) applyStimulus(1'b0, sel, pat, dp, ($urandom_range(0, 5) == 0));
        end
        hold(8, '0, P_BLANK, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
